// File: rtl/hamming_enc_sched.sv
// Round-robin scheduler sharing one Hamming(16,11) SECDED encoder between two
// 11-bit requesters, with a registered valid/ready codeword output stage.

module hamming_enc_core (
  input  logic        enc_en,
  input  logic [0:10] data,
  output logic [0:15] code
);
  logic       p1, p2, p4, p8;
  logic [0:14] hcode;

  // Parity bit at position 2^k covers every position whose index has bit k set
  always_comb begin
    p1    = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10];
    p2    = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[10];
    p4    = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
    p8    = ^data[4:10];
    hcode = {p1, p2, data[0], p4, data[1:3], p8, data[4:10]};
    code  = enc_en ? {hcode, ^hcode} : 16'h0000;
  end
endmodule

module hamming_enc_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in0_valid,
  input  logic [10:0]      in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [10:0]      in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_code,
  output logic             out_src,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int unsigned DATA_W = 11;
  localparam int unsigned CODE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state, next_state;
  logic                last_grant;
  logic                grant;
  logic                accept;
  logic                enc_en;
  logic [DATA_W-1:0]   hold_data;
  logic                hold_src;
  logic [CODE_W-1:0]   enc_code;

  // On a tie the requester that did not win last time is granted
  always_comb begin
    if (in0_valid && in1_valid) grant = ~last_grant;
    else                        grant = in1_valid;
    accept    = (state == IDLE) && en && (in0_valid || in1_valid) && !rst;
    in0_ready = accept && !grant;
    in1_ready = accept && grant;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    enc_en     = 1'b0;
    case (state)
      IDLE: if (accept) next_state = ENC;
      ENC: begin
        enc_en     = 1'b1;
        next_state = OUT;
      end
      OUT:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  hamming_enc_core u_enc (
    .enc_en (enc_en),
    .data   (hold_data),
    .code   (enc_code)
  );

  // Hold register, output stage and saturating handoff counter
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      hold_data  <= '0;
      hold_src   <= 1'b0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_src    <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if (accept) begin
        hold_data  <= grant ? in1_data : in0_data;
        hold_src   <= grant;
        last_grant <= grant;
      end
      if (state == ENC) begin
        out_code  <= enc_code;
        out_src   <= hold_src;
        out_valid <= 1'b1;
      end
      if ((state == OUT) && out_ready) begin
        out_valid <= 1'b0;
        if (word_cnt != {CNT_W{1'b1}}) word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hamming_enc_sched.sv
// Scoreboard bench for hamming_enc_sched: a 16-bit-counter instance and a
// 2-bit-counter instance run on identical stimulus.

module tb_hamming_enc_sched;
  logic        clk = 1'b0;
  logic        rst, en, in0_valid, in1_valid, out_ready;
  logic [10:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, out_src;
  logic [15:0] out_code, word_cnt;
  logic        s_in0_ready, s_in1_ready, s_out_valid, s_out_src;
  logic [15:0] s_out_code;
  logic [1:0]  s_word_cnt;

  always #5 clk = ~clk;

  hamming_enc_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_src(out_src), .word_cnt(word_cnt)
  );

  hamming_enc_sched #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_code(s_out_code),
    .out_src(s_out_src), .word_cnt(s_word_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder built from the positional definition of the code
  function automatic logic [15:0] model_enc(input logic [10:0] d);
    logic [15:0] pos;
    logic [15:0] c;
    logic        par;
    int          j;
    pos = '0;
    j   = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[10 - j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) if (((p >> k) & 1) == 1) par = par ^ pos[p];
      pos[1 << k] = par;
    end
    pos[0] = ^pos[15:1];
    for (int i = 0; i < 15; i++) c[15 - i] = pos[i + 1];
    c[0] = pos[0];
    return c;
  endfunction

  logic [16:0] sb[$];
  int          acc_src[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          last_acc = 0;
  int          model_cnt = 0;
  int          handoffs = 0;
  logic        prev_ov = 1'b0;
  logic        hold_chk = 1'b0;
  logic [15:0] hold_code;
  logic        hold_src;
  logic [15:0] last_code;
  logic        last_src;

  // Monitor: inputs are stable at the falling edge; the next rising edge commits
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (rst) begin
      check("rst_ready", 32'(in0_ready | in1_ready), 32'd0);
      sb.delete();
      model_cnt = 0;
      hold_chk  = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      check("ready_excl", 32'(in0_ready & in1_ready), 32'd0);
      if (!en) check("ready_en", 32'(in0_ready | in1_ready), 32'd0);
      check("word_cnt", 32'(word_cnt), 32'(model_cnt));
      check("sat_cnt", 32'(s_word_cnt), (model_cnt > 3) ? 32'd3 : 32'(model_cnt));
      check("sat_mirror", {13'd0, s_in0_ready, s_in1_ready, s_out_valid, s_out_code},
            {13'd0, in0_ready, in1_ready, out_valid, out_code});
      check("sat_src", 32'(s_out_src), 32'(out_src));
      if (hold_chk) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_code", 32'(out_code), 32'(hold_code));
        check("stall_src", 32'(out_src), 32'(hold_src));
        check("stall_ready", 32'(in0_ready | in1_ready), 32'd0);
      end
      if (in0_valid && in0_ready) begin
        sb.push_back({1'b0, model_enc(in0_data)});
        acc_src.push_back(0); acc_cyc.push_back(cyc); last_acc = cyc;
      end
      if (in1_valid && in1_ready) begin
        sb.push_back({1'b1, model_enc(in1_data)});
        acc_src.push_back(1); acc_cyc.push_back(cyc); last_acc = cyc;
      end
      if (out_valid && !prev_ov) check("latency", 32'(cyc - last_acc), 32'd2);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_code", 32'(out_code), 32'(e[15:0]));
          check("out_src", 32'(out_src), 32'(e[16]));
        end
        last_code = out_code;
        last_src  = out_src;
        model_cnt++;
        handoffs++;
      end
      hold_chk  = out_valid && !out_ready;
      hold_code = out_code;
      hold_src  = out_src;
      prev_ov   = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_handoffs(input int target, input int budget);
    for (int i = 0; i < budget && handoffs < target; i++) tick();
    check("handoff_timeout", 32'(handoffs >= target), 32'd1);
  endtask

  task automatic wait_out_valid(input int budget);
    for (int i = 0; i < budget && !out_valid; i++) tick();
    check("ov_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic send(input int src, input logic [10:0] d);
    int h;
    h = handoffs;
    if (src == 0) begin in0_valid = 1'b1; in0_data = d; end
    else          begin in1_valid = 1'b1; in1_data = d; end
    #1;
    check("send_ready", 32'(src == 0 ? in0_ready : in1_ready), 32'd1);
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    wait_handoffs(h + 1, 20);
  endtask

  initial begin
    int base, h;
    rst = 1'b1; en = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();

    send(0, 11'h7FF);
    check("t1_code", 32'(last_code), 32'h0000FFFF);
    check("t1_src", 32'(last_src), 32'd0);
    tick();
    check("t1_cnt", 32'(word_cnt), 32'd1);
    send(1, 11'h400);
    check("t2_code", 32'(last_code), 32'h0000E001);
    check("t2_src", 32'(last_src), 32'd1);
    send(1, 11'h000);
    check("t2_zero", 32'(last_code), 32'd0);
    tick();

    // Both requesters held active: grants alternate at a 3-cycle cadence
    base = acc_src.size();
    h    = handoffs;
    in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 40 && acc_src.size() < base + 6; i++) begin
      in0_data = 11'($urandom); in1_data = 11'($urandom);
      tick();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    wait_handoffs(h + 6, 30);
    check("rr_count", 32'(acc_src.size() - base), 32'd6);
    for (int i = 0; i < 6 && base + i < acc_src.size(); i++) begin
      check("rr_grant", 32'(acc_src[base + i]), 32'(i % 2));
      if (i > 0) check("rr_spacing", 32'(acc_cyc[base + i] - acc_cyc[base + i - 1]), 32'd3);
    end
    tick();
    check("rr_cnt", 32'(word_cnt), 32'd9);

    // Downstream stall for 5 cycles in OUT
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 11'($urandom);
    tick();
    in0_valid = 1'b0;
    wait_out_valid(10);
    in1_valid = 1'b1; in1_data = 11'($urandom);
    h = handoffs;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_cnt", 32'(word_cnt), 32'd9);
      check("stall_rdy1", 32'(in1_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("stall_release", 32'(handoffs), 32'(h + 1));
    wait_handoffs(h + 2, 20);
    in1_valid = 1'b0;
    tick(); tick();

    // en low blocks grants, but an in-flight word still completes
    en = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("en_block", 32'(in0_ready | in1_ready), 32'd0);
    end
    base = acc_src.size();
    h    = handoffs;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("en_done", 32'(handoffs), 32'(h + 1));
    check("en_noacc", 32'(acc_src.size()), 32'(base + 1));
    in0_valid = 1'b0; in1_valid = 1'b0; en = 1'b1;
    tick();

    // Reset while the word sits in OUT
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 11'($urandom);
    tick();
    in0_valid = 1'b0;
    wait_out_valid(10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ov", 32'(out_valid), 32'd0);
    check("rst_mid_cnt", 32'(word_cnt), 32'd0);
    check("rst_mid_scnt", 32'(s_word_cnt), 32'd0);
    out_ready = 1'b1;
    tick();

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) send(i % 2, 11'($urandom));
    tick();
    check("sat_final", 32'(s_word_cnt), 32'd3);
    check("wide_final", 32'(word_cnt), 32'd5);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
